// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end holding PC/MAR/IR, with a timed-out memory read
// handshake, mid-fetch jumps and back-to-back fetches.
module fetch_unit #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int OPC_W    = 5,
    parameter int RESET_PC = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_fetch_go,
    input  logic                    i_ir_take,
    input  logic                    i_pc_load,
    input  logic [DATA_W-1:0]       i_busc,
    input  logic                    i_err_clr,
    input  logic [DATA_W-1:0]       i_mem_rdata,
    input  logic                    i_mem_ack,
    output logic                    o_mem_req,
    output logic [ADDR_W-1:0]       o_bus_dir,
    output logic [OPC_W-1:0]        o_opcode,
    output logic [DATA_W-OPC_W-1:0] o_operand,
    output logic [ADDR_W-1:0]       o_pc,
    output logic                    o_ir_valid,
    output logic                    o_busy,
    output logic                    o_timeout_err
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_pc, r_mar, r_jmp_tgt;
    logic [DATA_W-1:0]  r_ir;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_jmp_pend, r_timeout_err;
    logic [ADDR_W-1:0]  w_busc, w_jmp_tgt;
    logic               w_jmp_pend, w_timeout, w_b2b;

    assign w_busc     = ADDR_W'(i_busc);
    assign w_timeout  = (r_state == REQ) && !i_mem_ack && (r_wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign w_b2b      = (r_state == VALID) && i_ir_take && i_fetch_go;
    // a jump landing in the same cycle as the ack still takes effect
    assign w_jmp_pend = r_jmp_pend | i_pc_load;
    assign w_jmp_tgt  = i_pc_load ? w_busc : r_jmp_tgt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!i_pc_load && i_fetch_go) ? REQ : IDLE;
            REQ:     w_next = i_mem_ack ? VALID : (w_timeout ? IDLE : REQ);
            VALID:   w_next = i_ir_take ? (i_fetch_go ? REQ : IDLE) : VALID;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_mem_req  = (r_state == REQ);
        o_ir_valid = (r_state == VALID);
        o_busy     = (r_state != IDLE) && (r_state != VALID);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= ADDR_W'(RESET_PC);
            r_mar      <= '0;
            r_ir       <= '0;
            r_wait_cnt <= '0;
            r_jmp_pend <= 1'b0;
            r_jmp_tgt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_pc_load) r_pc <= w_busc;
                    else if (i_fetch_go) begin
                        r_mar      <= r_pc;
                        r_wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        r_ir       <= i_mem_rdata;
                        r_pc       <= w_jmp_pend ? w_jmp_tgt : r_pc + ADDR_W'(1);
                        r_jmp_pend <= 1'b0;
                    end else if (w_timeout) begin
                        r_pc       <= w_jmp_pend ? w_jmp_tgt : r_pc;
                        r_jmp_pend <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        r_jmp_pend <= w_jmp_pend;
                        r_jmp_tgt  <= w_jmp_tgt;
                    end
                end
                VALID: begin
                    if (i_pc_load) r_pc <= w_busc;
                    if (w_b2b) begin
                        r_mar      <= i_pc_load ? w_busc : r_pc;
                        r_wait_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_timeout_err <= 1'b0;
        else if (w_timeout) r_timeout_err <= 1'b1;
        else if (i_err_clr) r_timeout_err <= 1'b0;
    end

    assign o_bus_dir     = r_mar;
    assign o_pc          = r_pc;
    assign o_opcode      = r_ir[DATA_W-1 -: OPC_W];
    assign o_operand     = r_ir[DATA_W-OPC_W-1:0];
    assign o_timeout_err = r_timeout_err;
endmodule
